// File: rtl/mrd_stage_seq.sv
// Mixed-radix DFT stage sequencer: sinks a packet, walks each radix stage's butterflies,
// waits for the write side between stages, then sources the result.
module mrd_stage_seq #(
  parameter int unsigned WR_TIMEOUT = 255,
  parameter int unsigned wADDR      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sop,
  input  logic                  in_valid,
  input  logic [wADDR-1:0]      dftpts,
  input  logic [2:0]            num_factors,
  input  logic [5:0][wADDR-1:0] bf_num,
  input  logic                  wr_done,
  output logic [2:0]            fsm,
  output logic [2:0]            stage_cnt,
  output logic                  in_ready,
  output logic                  rd_en,
  output logic [wADDR-1:0]      bf_idx,
  output logic                  rd_end,
  output logic                  src_en,
  output logic [wADDR-1:0]      src_idx,
  output logic                  src_end,
  output logic                  sop_drop,
  output logic                  cfg_err,
  output logic                  tmo_err
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSink   = 3'd1,
    StRd     = 3'd3,
    StWaitWr = 3'd4,
    StSource = 3'd5
  } state_e;

  localparam int unsigned TmoW = (WR_TIMEOUT < 2) ? 1 : $clog2(WR_TIMEOUT);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(WR_TIMEOUT - 1);
  localparam logic [wADDR-1:0] One = wADDR'(1);

  state_e                  state_q, state_d;
  logic [2:0]              stage_q, stage_d;
  logic [wADDR-1:0]        sink_q, sink_d;
  logic [wADDR-1:0]        bf_q, bf_d;
  logic [wADDR-1:0]        src_q, src_d;
  logic [TmoW-1:0]         wait_q, wait_d;
  logic                    pend_q, pend_d;
  logic [wADDR-1:0]        dft_q, dft_d;
  logic [2:0]              nf_q, nf_d;
  logic [5:0][wADDR-1:0]   bfn_q, bfn_d;

  logic in_ready_q, in_ready_d;
  logic rd_en_q, rd_en_d;
  logic rd_end_q, rd_end_d;
  logic src_en_q, src_en_d;
  logic src_end_q, src_end_d;
  logic sop_drop_q, sop_drop_d;
  logic cfg_err_q, cfg_err_d;
  logic tmo_err_q, tmo_err_d;

  logic acc;
  logic cfg_bad;

  assign acc = sop & in_valid;

  always_comb begin
    cfg_bad = (dftpts == '0) || (num_factors == 3'd0) || (num_factors > 3'd6);
    for (int s = 0; s < 6; s++) begin
      if ((3'(s) < num_factors) && (bf_num[s] == '0)) cfg_bad = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    sink_d     = sink_q;
    bf_d       = bf_q;
    src_d      = src_q;
    wait_d     = wait_q;
    pend_d     = pend_q;
    dft_d      = dft_q;
    nf_d       = nf_q;
    bfn_d      = bfn_q;
    sop_drop_d = 1'b0;
    cfg_err_d  = 1'b0;
    tmo_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        stage_d = 3'd0;
        pend_d  = 1'b0;
        if (acc) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            dft_d   = dftpts;
            nf_d    = num_factors;
            bfn_d   = bf_num;
            sink_d  = One;
            state_d = StSink;
          end
        end
      end
      StSink: begin
        // sop here is just data; a 1-point packet was fully received with its sop
        if (sink_q == dft_q) begin
          state_d = StRd;
          stage_d = 3'd0;
          bf_d    = '0;
        end else if (in_valid) begin
          sink_d = sink_q + One;
          if (sink_q == dft_q - One) begin
            state_d = StRd;
            stage_d = 3'd0;
            bf_d    = '0;
          end
        end
      end
      StRd: begin
        sop_drop_d = acc;
        if (wr_done) pend_d = 1'b1;
        if (bf_q == bfn_q[stage_q] - One) begin
          state_d = StWaitWr;
          wait_d  = '0;
        end else begin
          bf_d = bf_q + One;
        end
      end
      StWaitWr: begin
        sop_drop_d = acc;
        if (wr_done || pend_q) begin
          pend_d = 1'b0;
          if (stage_q == nf_q - 3'd1) begin
            state_d = StSource;
            src_d   = '0;
          end else begin
            state_d = StRd;
            stage_d = stage_q + 3'd1;
            bf_d    = '0;
          end
        end else if (wait_q == TmoLast) begin
          state_d   = StIdle;
          tmo_err_d = 1'b1;
          stage_d   = 3'd0;
          pend_d    = 1'b0;
        end else begin
          wait_d = wait_q + TmoW'(1);
        end
      end
      StSource: begin
        sop_drop_d = acc;
        if (src_q == dft_q - One) begin
          state_d = StIdle;
          stage_d = 3'd0;
        end else begin
          src_d = src_q + One;
        end
      end
      default: begin
        state_d = StIdle;
        stage_d = 3'd0;
        pend_d  = 1'b0;
      end
    endcase

    // Strobes are decoded from next state so they land in the same cycle as fsm
    in_ready_d = (state_d == StIdle) || (state_d == StSink);
    rd_en_d    = (state_d == StRd);
    rd_end_d   = rd_en_d && (bf_d == bfn_d[stage_d] - One);
    src_en_d   = (state_d == StSource);
    src_end_d  = src_en_d && (src_d == dft_d - One);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      stage_q    <= 3'd0;
      sink_q     <= '0;
      bf_q       <= '0;
      src_q      <= '0;
      wait_q     <= '0;
      pend_q     <= 1'b0;
      dft_q      <= '0;
      nf_q       <= 3'd0;
      bfn_q      <= '0;
      in_ready_q <= 1'b1;
      rd_en_q    <= 1'b0;
      rd_end_q   <= 1'b0;
      src_en_q   <= 1'b0;
      src_end_q  <= 1'b0;
      sop_drop_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      sink_q     <= sink_d;
      bf_q       <= bf_d;
      src_q      <= src_d;
      wait_q     <= wait_d;
      pend_q     <= pend_d;
      dft_q      <= dft_d;
      nf_q       <= nf_d;
      bfn_q      <= bfn_d;
      in_ready_q <= in_ready_d;
      rd_en_q    <= rd_en_d;
      rd_end_q   <= rd_end_d;
      src_en_q   <= src_en_d;
      src_end_q  <= src_end_d;
      sop_drop_q <= sop_drop_d;
      cfg_err_q  <= cfg_err_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign fsm       = state_q;
  assign stage_cnt = stage_q;
  assign in_ready  = in_ready_q;
  assign rd_en     = rd_en_q;
  assign bf_idx    = bf_q;
  assign rd_end    = rd_end_q;
  assign src_en    = src_en_q;
  assign src_idx   = src_q;
  assign src_end   = src_end_q;
  assign sop_drop  = sop_drop_q;
  assign cfg_err   = cfg_err_q;
  assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_mrd_stage_seq.sv
// Directed bench for mrd_stage_seq: hand-computed per-cycle expectations for nominal,
// early wr_done, dropped sop, bad config, stall, single-point, timeout and mid-packet reset.
module tb_mrd_stage_seq;

  localparam int unsigned W = 12;

  logic              clk = 1'b0;
  logic              rst, sop, in_valid, wr_done;
  logic [W-1:0]      dftpts;
  logic [2:0]        num_factors;
  logic [5:0][W-1:0] bf_num;
  logic [2:0]        fsm, stage_cnt;
  logic              in_ready, rd_en, rd_end, src_en, src_end, sop_drop, cfg_err, tmo_err;
  logic [W-1:0]      bf_idx, src_idx;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mrd_stage_seq #(.WR_TIMEOUT(16), .wADDR(W)) dut (
    .clk(clk), .rst(rst), .sop(sop), .in_valid(in_valid), .dftpts(dftpts),
    .num_factors(num_factors), .bf_num(bf_num), .wr_done(wr_done), .fsm(fsm),
    .stage_cnt(stage_cnt), .in_ready(in_ready), .rd_en(rd_en), .bf_idx(bf_idx),
    .rd_end(rd_end), .src_en(src_en), .src_idx(src_idx), .src_end(src_end),
    .sop_drop(sop_drop), .cfg_err(cfg_err), .tmo_err(tmo_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // errs = {sop_drop, cfg_err, tmo_err}; indices only compared while their strobe is due
  task automatic expc(input string tag, input int f, input int st, input bit re, input int bi,
                      input bit rend, input bit se, input int si, input bit send,
                      input logic [2:0] errs);
    logic [37:0] o, e;
    o = {fsm, stage_cnt, in_ready, rd_en, (rd_en ? bf_idx : 12'd0), rd_end,
         src_en, (src_en ? src_idx : 12'd0), src_end, sop_drop, cfg_err, tmo_err};
    e = {3'(f), 3'(st), (f <= 1), re, (re ? 12'(bi) : 12'd0), rend,
         se, (se ? 12'(si) : 12'd0), send, errs};
    chk(tag, 64'(o), 64'(e));
  endtask

  task automatic start(input int n, input bit gap);
    sop = 1'b1; in_valid = 1'b1;
    tick;
    sop = 1'b0; in_valid = 1'b0;
    expc("sink_first", 1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    for (int s = 2; s <= n; s++) begin
      if (gap) begin
        tick;
        expc("sink_stall", 1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
      end
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      if (s < n) expc("sink", 1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    end
    if (n == 1) tick;
  endtask

  task automatic rd_phase(input int stg, input int n, input bit early, input bit drop);
    for (int i = 0; i < n; i++) begin
      expc("rd", 3, stg, 1, i, (i == n - 1), 0, 0, 0, {(drop && i == 1), 2'b00});
      if (early && i == 0) wr_done = 1'b1;
      if (drop && i == 0) begin
        sop = 1'b1; in_valid = 1'b1;
      end
      tick;
      wr_done = 1'b0; sop = 1'b0; in_valid = 1'b0;
    end
  endtask

  task automatic wait_phase(input int stg, input int n, input bit pulse);
    for (int k = 1; k <= n; k++) begin
      expc("wait_wr", 4, stg, 0, 0, 0, 0, 0, 0, 3'b000);
      if (pulse && k == n) wr_done = 1'b1;
      tick;
      wr_done = 1'b0;
    end
  endtask

  task automatic src_phase(input int stg, input int n);
    for (int i = 0; i < n; i++) begin
      expc("src", 5, stg, 0, 0, 0, 1, i, (i == n - 1), 3'b000);
      tick;
    end
    expc("idle_after_src", 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
  endtask

  task automatic bad_cfg(input string tag);
    sop = 1'b1; in_valid = 1'b1;
    tick;
    sop = 1'b0; in_valid = 1'b0;
    expc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010);
    tick;
    expc({tag, "_clear"}, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
  endtask

  initial begin
    rst = 1'b1; sop = 1'b0; in_valid = 1'b0; wr_done = 1'b0;
    dftpts = '0; num_factors = 3'd0; bf_num = '0;
    tick;
    tick;
    expc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    chk("reset_bf_idx", 64'(bf_idx), 64'd0);
    chk("reset_src_idx", 64'(src_idx), 64'd0);
    rst = 1'b0;

    // Nominal two-stage packet, sop on the first cycle out of reset
    dftpts = 12'd12; num_factors = 3'd2; bf_num[0] = 12'd4; bf_num[1] = 12'd3;
    start(12, 1'b0);
    rd_phase(0, 4, 1'b0, 1'b0);
    wait_phase(0, 5, 1'b1);
    rd_phase(1, 3, 1'b0, 1'b0);
    wait_phase(1, 5, 1'b1);
    src_phase(1, 12);

    // Back-to-back packet with early wr_done and a dropped sop during RD
    dftpts = 12'd4; bf_num[0] = 12'd2; bf_num[1] = 12'd2;
    start(4, 1'b0);
    rd_phase(0, 2, 1'b1, 1'b1);
    wait_phase(0, 1, 1'b0);
    rd_phase(1, 2, 1'b0, 1'b0);
    wait_phase(1, 2, 1'b1);
    src_phase(1, 4);

    // Invalid configurations
    dftpts = 12'd0; num_factors = 3'd2;
    bad_cfg("cfg_dft0");
    dftpts = 12'd4; num_factors = 3'd7;
    bad_cfg("cfg_nf7");
    num_factors = 3'd0;
    bad_cfg("cfg_nf0");
    num_factors = 3'd2; bf_num[1] = 12'd0;
    bad_cfg("cfg_bf0");

    // Gapped sink, single-butterfly stage; unused bf_num[1]=0 must be accepted
    dftpts = 12'd12; num_factors = 3'd1; bf_num[0] = 12'd1;
    start(12, 1'b1);
    rd_phase(0, 1, 1'b0, 1'b0);
    wait_phase(0, 3, 1'b1);
    src_phase(0, 12);

    // Single-point packet
    dftpts = 12'd1;
    start(1, 1'b0);
    rd_phase(0, 1, 1'b0, 1'b0);
    wait_phase(0, 1, 1'b1);
    src_phase(0, 1);

    // Write-side timeout after 16 WAIT_WR cycles
    dftpts = 12'd2; num_factors = 3'd2; bf_num[0] = 12'd2; bf_num[1] = 12'd2;
    start(2, 1'b0);
    rd_phase(0, 2, 1'b0, 1'b0);
    wait_phase(0, 16, 1'b0);
    expc("timeout", 0, 0, 0, 0, 0, 0, 0, 0, 3'b001);
    tick;
    expc("timeout_clear", 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);

    // Reset in the middle of SOURCE, then a fresh packet right away
    dftpts = 12'd12; num_factors = 3'd1; bf_num[0] = 12'd3;
    start(12, 1'b0);
    rd_phase(0, 3, 1'b0, 1'b0);
    wait_phase(0, 2, 1'b1);
    for (int i = 0; i <= 5; i++) begin
      expc("src_pre_rst", 5, 0, 0, 0, 0, 1, i, 0, 3'b000);
      if (i < 5) tick;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    expc("rst_mid_src", 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    dftpts = 12'd3; bf_num[0] = 12'd2;
    start(3, 1'b0);
    rd_phase(0, 2, 1'b0, 1'b0);
    wait_phase(0, 2, 1'b1);
    src_phase(0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mrd_stage_seq.md
MRD_STAGE_SEQ -- requirements
Module: mrd_stage_seq

Interface
REQ-001 Parameter WR_TIMEOUT, default 255: maximum cycles spent in WAIT_WR before an abort.
REQ-002 Parameter wADDR, default 12: width of the point and butterfly counters.
REQ-003 clk  in  1  the single clock; every register updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 sop  in  1  start of packet; qualified by in_valid.
REQ-006 in_valid  in  1  sink sample valid.
REQ-007 dftpts  in  wADDR  packet length in points, sampled with the accepted sop.
REQ-008 num_factors  in  3  number of radix stages (1..6), sampled with the accepted sop.
REQ-009 bf_num  in  6x wADDR  butterflies per stage (dftpts/Nf[s]), sampled with the accepted sop.
REQ-010 wr_done  in  1  one-cycle pulse from the write side: the current stage's writes are complete.
REQ-011 fsm  out  3  state code: IDLE=0, SINK=1, RD=3, WAIT_WR=4, SOURCE=5.
REQ-012 stage_cnt  out  3  current radix stage, 0-based.
REQ-013 in_ready  out  1  high in IDLE and SINK.
REQ-014 rd_en  out  1  butterfly read strobe.
REQ-015 bf_idx  out  wADDR  butterfly index; valid while rd_en=1.
REQ-016 rd_end  out  1  pulse on the last butterfly of a stage.
REQ-017 src_en  out  1  source read strobe.
REQ-018 src_idx  out  wADDR  output point index; valid while src_en=1.
REQ-019 src_end  out  1  pulse on the last source point.
REQ-020 sop_drop  out  1  pulse: sop was ignored.
REQ-021 cfg_err  out  1  pulse: invalid configuration was rejected.
REQ-022 tmo_err  out  1  pulse: WAIT_WR timed out.

Function
REQ-023 All outputs shall be registered.
REQ-024 The state register shall change only on clk.
REQ-025 IDLE -> SINK on sop&in_valid with a valid configuration.
- Captures dftpts, num_factors and bf_num.
- That sample counts as sample 1.
REQ-026 A configuration is invalid when dftpts==0, num_factors==0, num_factors>6, or any bf_num[s]==0 for s<num_factors.
- On sop&in_valid with an invalid configuration: stay in IDLE and pulse cfg_err for 1 cycle.
REQ-027 SINK counts in_valid cycles.
- When the count reaches the captured dftpts, go to RD with stage_cnt=0.
- in_valid low shall stall the count without a state change.
REQ-028 sop asserted in SINK shall be treated as data.
REQ-029 sop asserted in RD, WAIT_WR or SOURCE shall be ignored and shall pulse sop_drop.
REQ-030 RD: rd_en=1 on every cycle in RD.
- bf_idx runs 0,1,..,bf_num[stage_cnt]-1, incrementing by one per cycle.
- rd_end=1 together with the last index.
- The next state is WAIT_WR.
REQ-031 The first rd_en shall appear on the first clock edge after the RD entry condition (one cycle of latency).
REQ-032 WAIT_WR, on wr_done (or on a pending wr_done, see REQ-033):
- stage_cnt==num_factors-1 -> SOURCE.
- Otherwise stage_cnt+1 -> RD.
REQ-033 A wr_done arriving during RD shall be latched as pending.
- It is consumed on the first WAIT_WR cycle.
- Further wr_done pulses while one is already pending are discarded.
REQ-034 The WAIT_WR cycle counter shall reset on entry.
- If it reaches WR_TIMEOUT without wr_done: go to IDLE, pulse tmo_err, and clear stage_cnt and the pending flag.
REQ-035 SOURCE: src_en=1 on every cycle in SOURCE.
- src_idx runs 0..dftpts-1, incrementing by one per cycle.
- src_end=1 together with the last index.
- The next state is IDLE.
REQ-036 A sop&in_valid in the cycle after src_end shall be accepted (back-to-back packets).
REQ-037 Counters shall be wADDR wide and shall never wrap: every terminal compare is an equality on count-1.
REQ-038 bf_num[s]==1 shall give a single-cycle RD with rd_en, bf_idx=0 and rd_end all in the same cycle.
REQ-039 dftpts==1 shall give a 1-cycle SINK and a 1-cycle SOURCE.
REQ-040 stage_cnt shall clear to 0 in IDLE.
REQ-041 Error pulses shall last exactly 1 cycle.

Reset
REQ-042 While rst=1:
- fsm=IDLE, stage_cnt=0, and all counters and the pending flag = 0.
- Every output = 0, except in_ready=1.
REQ-043 rst asserted mid-packet in any state shall abort the packet at the next edge; no partial strobes follow.
REQ-044 The first sop shall be accepted on the first cycle after rst deasserts.

Verification
REQ-045 Nominal two-stage packet.
- Stimulus: dftpts=12, num_factors=2, bf_num={4,3}; 12 in_valid; wr_done 5 cycles after each rd_end.
- Response: RD bf_idx 0..3 at stage 0, then 0..2 at stage 1; SOURCE src_idx 0..11; src_end; IDLE.
- Packet lasts 12+4+5+3+5+12 cycles from sop.
REQ-046 Early wr_done.
- Stimulus: wr_done pulsed during RD of stage 0.
- Response: exactly 1 WAIT_WR cycle, then RD of stage 1.
REQ-047 Timeout.
- Stimulus: WR_TIMEOUT=16; no wr_done.
- Response: tmo_err pulses 16 cycles after WAIT_WR entry; fsm=IDLE; stage_cnt=0.
REQ-048 Bad configuration and dropped sop.
- Stimulus: sop with dftpts=0 -> cfg_err=1 for 1 cycle, fsm stays IDLE.
- Stimulus: sop during RD -> sop_drop=1 for 1 cycle, sequence unchanged.
REQ-049 Sink stall and single-butterfly stage.
- Stimulus: in_valid gapped 1-of-2 during SINK; bf_num[0]=1.
- Response: SINK ends on the 12th valid; a 1-cycle RD with rd_end.
REQ-050 Reset mid-SOURCE.
- Stimulus: rst at src_idx=5.
- Response: the next cycle has src_en=0, fsm=IDLE, in_ready=1; a new packet runs normally.
